fpu_ss_wb_arbiter: RTL and testbench

//  Arbitrates the single FP register-file write port between FPnew results and memory (load) results.

---
 rtl/fpu_ss_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpu_ss_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_wb_arbiter.sv
// fpu_ss_wb_arbiter
// Shares the single FP register-file write port between FPnew results and
// memory (load) results. Loads cannot be back-pressured, so they retire
// through a small in-order buffer; FPnew results are held off via fpu_ready_o.
// Every FPR write also clears the matching rd-scoreboard entry.
//
// Configuration macro: FPU_SS_WB_STARVE_GUARD_EN
//   defined   : a starvation counter forces an FPU grant after STARVE_LIMIT
//               stalled cycles.
//   undefined : strict memory priority, no counter.
module fpu_ss_wb_arbiter #(
  parameter int MEM_BUF_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  fpu_valid_i,
  output logic                  fpu_ready_o,
  input  logic                  fpu_rd_is_fp_i,
  input  logic [4:0]            fpu_rd_i,
  input  logic [DATA_WIDTH-1:0] fpu_data_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_we_i,
  input  logic [4:0]            mem_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_space_o,
  output logic                  fpr_we_o,
  output logic [4:0]            fpr_waddr_o,
  output logic [DATA_WIDTH-1:0] fpr_wdata_o,
  output logic                  wb_src_o,
  output logic                  sb_clr_o,
  output logic [4:0]            sb_clr_addr_o,
  output logic                  overflow_o
);

  localparam int PTR_W = (MEM_BUF_DEPTH > 1) ? $clog2(MEM_BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(MEM_BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MEM_BUF_DEPTH);

  logic [4:0]            buf_rd   [MEM_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data [MEM_BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  mem_space_q, overflow_q;

  logic buf_empty, buf_full, load_in, mem_cand, fpu_fp_req, force_fpu;
  logic fpu_grant, mem_grant, push, pop, push_ok, drop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign buf_empty  = (count == '0);
  assign buf_full   = (count == CNT_FULL);
  assign load_in    = mem_valid_i & mem_we_i;         // store responses never write
  assign mem_cand   = ~buf_empty | load_in;           // head first; bypass only when empty
  assign fpu_fp_req = fpu_valid_i & fpu_rd_is_fp_i;

`ifdef FPU_SS_WB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  assign force_fpu = (starve_cnt == SC_W'(STARVE_LIMIT));

  // Count stalled FP results; any FPU handshake restarts the count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (fpu_valid_i && fpu_ready_o) begin
      starve_cnt <= '0;
    end else if (fpu_fp_req && !fpu_grant) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end
`else
  // Strict memory priority: the limit is irrelevant here and this is always 0.
  assign force_fpu = (STARVE_LIMIT < 0);
`endif

  // Nothing is granted while reset is asserted, so no write leaks out.
  assign fpu_grant = rst_ni & fpu_fp_req & (~mem_cand | force_fpu);
  assign mem_grant = rst_ni & mem_cand & ~fpu_grant;

  // A load that is not written this cycle goes to the tail.
  assign push    = load_in & (~buf_empty | fpu_grant);
  assign pop     = mem_grant & ~buf_empty;
  assign push_ok = push & (~buf_full | pop);          // a same-cycle pop frees the slot
  assign drop    = push & buf_full & ~pop;

  assign fpu_ready_o = rst_ni & fpu_valid_i & (~fpu_rd_is_fp_i | fpu_grant);

  // Zero-latency write-port mux.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    fpr_we_o    = fpu_grant | mem_grant;
    wb_src_o    = mem_grant;
    fpr_waddr_o = fpu_rd_i;
    fpr_wdata_o = fpu_data_i;
    if (mem_grant) begin
      if (!buf_empty) begin
        fpr_waddr_o = buf_rd[rd_ptr];
        fpr_wdata_o = buf_data[rd_ptr];
      end else begin
        fpr_waddr_o = mem_rd_i;
        fpr_wdata_o = mem_data_i;
      end
    end
  end

  assign sb_clr_o      = fpr_we_o;
  assign sb_clr_addr_o = fpr_waddr_o;

  // Occupancy update from push/pop.
  always_comb begin
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push_ok) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Buffer control state, sticky overflow and registered space flag.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_ni) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      overflow_q  <= 1'b0;
      mem_space_q <= 1'b1;
    end else begin
      count       <= count_next;
      mem_space_q <= (count_next < CNT_FULL);
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      if (drop)    overflow_q <= 1'b1;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; count gates every read, so stale entries are never seen.
    if (push_ok) begin
      buf_rd[wr_ptr]   <= mem_rd_i;
      buf_data[wr_ptr] <= mem_data_i;
    end
  end

  assign mem_space_o = mem_space_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// tb_fpu_ss_wb_arbiter
// Scoreboard bench: expected FPR writes are queued as stimulus is planned and
// popped whenever the DUT asserts fpr_we_o. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_fpu_ss_wb_arbiter;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          fpu_valid_i, fpu_ready_o, fpu_rd_is_fp_i;
  logic [4:0]    fpu_rd_i;
  logic [DW-1:0] fpu_data_i;
  logic          mem_valid_i, mem_we_i;
  logic [4:0]    mem_rd_i;
  logic [DW-1:0] mem_data_i;
  logic          mem_space_o, fpr_we_o, wb_src_o, sb_clr_o, overflow_o;
  logic [4:0]    fpr_waddr_o, sb_clr_addr_o;
  logic [DW-1:0] fpr_wdata_o;

  always #5 clk_i = ~clk_i;

  fpu_ss_wb_arbiter #(
    .MEM_BUF_DEPTH(2),
    .STARVE_LIMIT (4),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fpu_valid_i   (fpu_valid_i),
    .fpu_ready_o   (fpu_ready_o),
    .fpu_rd_is_fp_i(fpu_rd_is_fp_i),
    .fpu_rd_i      (fpu_rd_i),
    .fpu_data_i    (fpu_data_i),
    .mem_valid_i   (mem_valid_i),
    .mem_we_i      (mem_we_i),
    .mem_rd_i      (mem_rd_i),
    .mem_data_i    (mem_data_i),
    .mem_space_o   (mem_space_o),
    .fpr_we_o      (fpr_we_o),
    .fpr_waddr_o   (fpr_waddr_o),
    .fpr_wdata_o   (fpr_wdata_o),
    .wb_src_o      (wb_src_o),
    .sb_clr_o      (sb_clr_o),
    .sb_clr_addr_o (sb_clr_addr_o),
    .overflow_o    (overflow_o)
  );

  typedef struct packed {
    logic          src;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

`ifdef FPU_SS_WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void expect_wr(input logic src, input logic [4:0] rd, input logic [DW-1:0] d);
    exp_q.push_back(wr_t'{src, rd, d});
  endfunction

  task automatic idle_inputs();
    fpu_valid_i = 1'b0; fpu_rd_is_fp_i = 1'b1; fpu_rd_i = '0; fpu_data_i = '0;
    mem_valid_i = 1'b0; mem_we_i = 1'b0; mem_rd_i = '0; mem_data_i = '0;
  endtask

  // Falling-edge sample; any write must match the head of the scoreboard.
  task automatic sample();
    wr_t e;
    @(negedge clk_i);
    if (fpr_we_o) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {63'd0, fpr_we_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr", {26'd0, wb_src_o, fpr_waddr_o, fpr_wdata_o}, {26'd0, e});
        check("sb_clr", {58'd0, sb_clr_o, sb_clr_addr_o}, {58'd0, 1'b1, e.rd});
      end
    end else begin
      check("sb_idle", {63'd0, sb_clr_o}, 64'd0);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_cyc;
    int fidx;

    // Reset
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) begin
      sample();
      check("rst_we", {63'd0, fpr_we_o}, 64'd0);
      advance();
    end
    rst_ni = 1'b1;
    sample();
    check("rst_space", {63'd0, mem_space_o}, 64'd1);
    check("rst_ovf",   {63'd0, overflow_o},  64'd0);
    check("rst_sbclr", {63'd0, sb_clr_o},    64'd0);
    advance();

    // 1: FPU only, same-cycle write
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd5; fpu_data_i = 32'h3F80_0000;
    expect_wr(1'b0, 5'd5, 32'h3F80_0000);
    sample();
    check("t1_ready", {63'd0, fpu_ready_o}, 64'd1);
    advance();

    // Non-FP FPU result: consumed, no write
    fpu_rd_is_fp_i = 1'b0; fpu_rd_i = 5'd6;
    sample();
    check("nonfp_ready", {63'd0, fpu_ready_o}, 64'd1);
    advance();
    idle_inputs();

    // 5: store response ignored
    mem_valid_i = 1'b1; mem_we_i = 1'b0; mem_rd_i = 5'd2; mem_data_i = 32'hDEAD_BEEF;
    sample();
    advance();
    idle_inputs();
    // Buffer must still be empty: a lone FPU result is written immediately
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd9; fpu_data_i = 32'h4000_0000;
    expect_wr(1'b0, 5'd9, 32'h4000_0000);
    sample();
    check("t5_space", {63'd0, mem_space_o}, 64'd1);
    check("t5_ready", {63'd0, fpu_ready_o}, 64'd1);
    advance();
    idle_inputs();

    // 2: collision, load first then FPU
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd3; fpu_data_i = 32'h1111_0003;
    mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_rd_i = 5'd7; mem_data_i = 32'h2222_0007;
    expect_wr(1'b1, 5'd7, 32'h2222_0007);
    expect_wr(1'b0, 5'd3, 32'h1111_0003);
    sample();
    check("t2_stall", {63'd0, fpu_ready_o}, 64'd0);
    advance();
    mem_valid_i = 1'b0;
    sample();
    check("t2_ready", {63'd0, fpu_ready_o}, 64'd1);
    advance();
    idle_inputs();
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: starvation, FPU held while loads rd1..8 arrive back to back
    for (int i = 1; i <= 8; i++) begin
      if (GUARD && i == 5) expect_wr(1'b0, 5'd20, 32'hF000_0014);
      expect_wr(1'b1, 5'(i), 32'hA000_0000 | i);
    end
    if (!GUARD) expect_wr(1'b0, 5'd20, 32'hF000_0014);
    acc_cyc = -1;
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd20; fpu_data_i = 32'hF000_0014;
    for (int c = 0; c < 12; c++) begin
      mem_valid_i = (c < 8); mem_we_i = 1'b1;
      mem_rd_i = 5'(c + 1); mem_data_i = 32'hA000_0000 | (c + 1);
      sample();
      if (c == 0) check("t3_stall", {63'd0, fpu_ready_o}, 64'd0);
      if (fpu_ready_o && acc_cyc < 0) acc_cyc = c;
      advance();
      if (acc_cyc >= 0) fpu_valid_i = 1'b0;
    end
    idle_inputs();
    check("t3_fpu_cycle", 64'(acc_cyc), GUARD ? 64'd4 : 64'd8);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // 4 + 6: continuous loads with a stream of FPU results, then reset in cycle 15
    if (GUARD) begin
      for (int i = 0; i < 12; i++) begin
        expect_wr(1'b1, 5'(i), 32'hA000_0000 | i);
        if (i % 4 == 3) expect_wr(1'b0, 5'(16 + i / 4), 32'hF000_0000 | (i / 4));
      end
    end else begin
      for (int i = 0; i < 15; i++) expect_wr(1'b1, 5'(i), 32'hA000_0000 | i);
    end
    fidx = 0;
    for (int c = 0; c < 16; c++) begin
      rst_ni = (c != 15);
      fpu_valid_i = 1'b1; fpu_rd_is_fp_i = 1'b1;
      fpu_rd_i = 5'(16 + fidx); fpu_data_i = 32'hF000_0000 | fidx;
      mem_valid_i = (c < 15); mem_we_i = 1'b1;
      mem_rd_i = 5'(c); mem_data_i = 32'hA000_0000 | c;
      sample();
      if (c == 10) check("t4_space_full", {63'd0, mem_space_o}, GUARD ? 64'd0 : 64'd1);
      if (c == 14) check("t4_ovf_pre",    {63'd0, overflow_o},  64'd0);
      if (c == 15) begin
        check("t4_ovf_set",   {63'd0, overflow_o},  GUARD ? 64'd1 : 64'd0);
        check("t4_space_rst", {63'd0, mem_space_o}, GUARD ? 64'd0 : 64'd1);
        check("t6_rst_we",    {63'd0, fpr_we_o},    64'd0);
        check("t6_rst_ready", {63'd0, fpu_ready_o}, 64'd0);
      end
      if (fpu_ready_o) fidx++;
      advance();
    end
    rst_ni = 1'b1;
    idle_inputs();
    sample();
    check("t6_space", {63'd0, mem_space_o}, 64'd1);
    check("t6_ovf",   {63'd0, overflow_o},  64'd0);
    check("t6_we",    {63'd0, fpr_we_o},    64'd0);
    advance();
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // Buffered loads were discarded: FPU goes straight through
    fpu_valid_i = 1'b1; fpu_rd_i = 5'd9; fpu_data_i = 32'h4040_0000;
    expect_wr(1'b0, 5'd9, 32'h4040_0000);
    sample();
    check("t6_fpu_ready", {63'd0, fpu_ready_o}, 64'd1);
    advance();
    idle_inputs();
    sample();
    advance();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
